// File: rtl/neuron_mac_if.sv
// neuron_mac_if: start/bias command, pixel/weight stream
// and result bundle for the multiply-accumulate neuron.
interface neuron_mac_if #(
  parameter int X_W   = 8,
  parameter int W_W   = 16,
  parameter int OUT_W = 32
);
  logic                    start;
  logic signed [OUT_W-1:0] bias;
  logic                    x_valid;
  logic                    x_ready;
  logic [X_W-1:0]          x;
  logic signed [W_W-1:0]   w;
  logic                    busy;
  logic                    done;
  logic signed [OUT_W-1:0] out;
  logic                    overflow;

  modport master (
    output start, bias, x_valid, x, w,
    input  x_ready, busy, done, out, overflow
  );

  modport slave (
    input  start, bias, x_valid, x, w,
    output x_ready, busy, done, out, overflow
  );
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac: streaming pixel*weight dot product onto a
// bias, with saturated and optionally ReLU'd result.
module neuron_mac #(
  parameter int X_W      = 8,
  parameter int W_W      = 16,
  parameter int N_INPUTS = 12288,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 32,
  parameter int RELU     = 0
) (
  input logic         clk,
  input logic         rst,
  neuron_mac_if.slave bus
);
  localparam int P_W   = X_W + W_W + 1;
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, ACCUM, FLUSH, FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_p;
  logic                    r_p_valid;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [OUT_W-1:0] r_out;
  logic                    r_ov;
  logic                    r_done;

  logic                    w_x_ready;
  logic                    w_busy;
  logic                    w_start;
  logic                    w_accept;
  logic                    w_last;
  logic signed [P_W-1:0]   w_xs;
  logic signed [P_W-1:0]   w_ws;
  logic signed [P_W-1:0]   w_prod;
  logic signed [OUT_W-1:0] w_sat;
  logic signed [OUT_W-1:0] w_res;
  logic                    w_clip;

  assign w_start  = (r_state == IDLE) && bus.start;
  assign w_accept = (r_state == ACCUM) && bus.x_valid;
  assign w_last   = w_accept && (r_cnt == LAST);

  // pixel is zero-extended, weight sign-extended
  assign w_xs   = {{W_W{1'b0}}, 1'b0, bus.x};
  assign w_ws   = {{(X_W+1){bus.w[W_W-1]}}, bus.w};
  assign w_prod = w_xs * w_ws;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next state and handshake outputs
  always_comb begin
    w_next    = r_state;
    w_x_ready = 1'b0;
    w_busy    = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = ACCUM;
      end
      ACCUM: begin
        w_x_ready = 1'b1;
        if (w_last) w_next = FLUSH;
      end
      FLUSH:   w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // stage 1: product register and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p       <= '0;
      r_p_valid <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_p_valid <= w_accept;
      if (w_accept) begin
        r_p   <= ACC_W'(w_prod);
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_start) r_cnt <= '0;
    end
  end

  // stage 2: accumulator, seeded with the bias
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_start) begin
      r_acc <= ACC_W'(bus.bias);
    end else if (r_p_valid) begin
      r_acc <= r_acc + r_p;
    end
  end

  // saturate to OUT_W, then optional ReLU
  always_comb begin
    w_clip = 1'b0;
    w_sat  = r_acc[OUT_W-1:0];
    if (r_acc > MAXV) begin
      w_clip = 1'b1;
      w_sat  = MAXV[OUT_W-1:0];
    end else if (r_acc < MINV) begin
      w_clip = 1'b1;
      w_sat  = MINV[OUT_W-1:0];
    end
    w_res = w_sat;
    if (RELU != 0 && w_sat[OUT_W-1]) w_res = '0;
  end

  // output stage loaded in FINISH with a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_ov   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == FINISH) begin
        r_out  <= w_res;
        r_ov   <= w_clip;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.x_ready  = w_x_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.out      = r_out;
  assign bus.overflow = r_ov;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed checks of three neuron_mac
// variants fed from one shared stimulus stream.
module tb_neuron_mac;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [31:0] bias = '0;
  logic x_valid = 1'b0;
  logic [7:0] x = '0;
  logic signed [15:0] w = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0] vx [4];
  logic signed [15:0] vw [4];

  always #5 clk = ~clk;

  neuron_mac_if #(.X_W(8), .W_W(16), .OUT_W(32)) ifa ();
  neuron_mac_if #(.X_W(8), .W_W(16), .OUT_W(16)) ifb ();
  neuron_mac_if #(.X_W(8), .W_W(16), .OUT_W(32)) ifc ();

  assign ifa.start = start;
  assign ifa.bias = bias;
  assign ifa.x_valid = x_valid;
  assign ifa.x = x;
  assign ifa.w = w;
  assign ifb.start = start;
  assign ifb.bias = bias[15:0];
  assign ifb.x_valid = x_valid;
  assign ifb.x = x;
  assign ifb.w = w;
  assign ifc.start = start;
  assign ifc.bias = bias;
  assign ifc.x_valid = x_valid;
  assign ifc.x = x;
  assign ifc.w = w;

  neuron_mac #(.N_INPUTS(4), .ACC_W(40), .OUT_W(32),
    .RELU(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  neuron_mac #(.N_INPUTS(4), .ACC_W(40), .OUT_W(16),
    .RELU(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  neuron_mac #(.N_INPUTS(4), .ACC_W(40), .OUT_W(32),
    .RELU(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic do_start(input logic signed [31:0] b);
    start = 1'b1;
    bias = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_beat(input logic [7:0] xv,
                         input logic signed [15:0] wv,
                         input bit gap);
    x_valid = 1'b1;
    x = xv;
    w = wv;
    @(posedge clk); #1;
    x_valid = 1'b0;
    if (gap) begin
      x = 8'($urandom);
      w = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ifa.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run4(input logic signed [31:0] b,
                      input bit gap, output int lat);
    do_start(b);
    for (int i = 0; i < 4; i++)
      do_beat(vx[i], vw[i], gap && i < 3);
    wait_done(lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ifa.busy !== 1'b0 || ifa.x_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs busy=%b x_ready=%b want 0/0",
               ifa.busy, ifa.x_ready);
    end
    checks++;
    if (ifa.done !== 1'b0 || ifa.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags done=%b ov=%b want 0/0",
               ifa.done, ifa.overflow);
    end
    checks++;
    if (ifa.out !== 0 || ifb.out !== 0) begin
      errors++;
      $display("FAIL reset_out a=%0d b=%0d want 0",
               ifa.out, ifb.out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    for (int i = 0; i < 4; i++) begin
      vx[i] = 8'd255;
      vw[i] = -16'sd32768;
    end
    run4(0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL b2b_latency got %0d want 2", lat);
    end
    checks++;
    if (ifa.out !== -33423360 || ifa.overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_out got %0d ov=%b want -33423360 ov=0",
               ifa.out, ifa.overflow);
    end
    checks++;
    if (ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy got %b want 0", ifa.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_pulse got %b want 0", ifa.done);
    end
  endtask

  task automatic test_saturation;
    int lat;
    for (int i = 0; i < 4; i++) begin
      vx[i] = 8'd255;
      vw[i] = 16'sd32767;
    end
    run4(0, 1'b0, lat);
    checks++;
    if (ifb.out !== 32767 || ifb.overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos got %0d ov=%b want 32767 ov=1",
               ifb.out, ifb.overflow);
    end
    checks++;
    if (ifa.out !== 33422340 || ifa.overflow !== 1'b0) begin
      errors++;
      $display("FAIL wide_pos got %0d ov=%b want 33422340 ov=0",
               ifa.out, ifa.overflow);
    end
    for (int i = 0; i < 4; i++) vw[i] = -16'sd32768;
    run4(0, 1'b0, lat);
    checks++;
    if (ifb.out !== -32768 || ifb.overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg got %0d ov=%b want -32768 ov=1",
               ifb.out, ifb.overflow);
    end
  endtask

  task automatic test_gaps;
    int lat;
    vx = '{8'd10, 8'd20, 8'd30, 8'd40};
    vw = '{16'sd1, -16'sd2, 16'sd3, -16'sd4};
    checks++;
    if (ifa.x_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b want 0", ifa.x_ready);
    end
    do_start(5);
    checks++;
    if (ifa.x_ready !== 1'b1) begin
      errors++;
      $display("FAIL accum_ready got %b want 1", ifa.x_ready);
    end
    for (int i = 0; i < 4; i++)
      do_beat(vx[i], vw[i], i < 3);
    checks++;
    if (ifa.x_ready !== 1'b0 || ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_hs ready=%b busy=%b want 0/1",
               ifa.x_ready, ifa.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (ifa.x_ready !== 1'b0 || ifa.done !== 1'b0) begin
      errors++;
      $display("FAIL finish_hs ready=%b done=%b want 0/0",
               ifa.x_ready, ifa.done);
    end
    @(posedge clk); #1;
    checks++;
    if (ifa.done !== 1'b1 || ifa.out !== -95) begin
      errors++;
      $display("FAIL gap_out done=%b out=%0d want 1/-95",
               ifa.done, ifa.out);
    end
    run4(5, 1'b0, lat);
    checks++;
    if (lat !== 2 || ifa.out !== -95) begin
      errors++;
      $display("FAIL nogap_out lat=%0d out=%0d want 2/-95",
               lat, ifa.out);
    end
  endtask

  task automatic test_relu;
    int lat;
    for (int i = 0; i < 4; i++) begin
      vx[i] = 8'd1;
      vw[i] = 16'sd10;
    end
    run4(-100, 1'b0, lat);
    checks++;
    if (ifc.out !== 0 || ifc.overflow !== 1'b0) begin
      errors++;
      $display("FAIL relu_neg got %0d ov=%b want 0 ov=0",
               ifc.out, ifc.overflow);
    end
    checks++;
    if (ifa.out !== -60) begin
      errors++;
      $display("FAIL norelu_neg got %0d want -60", ifa.out);
    end
    run4(100, 1'b0, lat);
    checks++;
    if (ifc.out !== 140) begin
      errors++;
      $display("FAIL relu_pos got %0d want 140", ifc.out);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    do_start(50);
    do_beat(8'd1, 16'sd1, 1'b0);
    do_beat(8'd1, 16'sd1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ifa.busy !== 1'b0 || ifa.x_ready !== 1'b0 ||
        ifa.out !== 0) begin
      errors++;
      $display("FAIL midrst busy=%b ready=%b out=%0d want 0/0/0",
               ifa.busy, ifa.x_ready, ifa.out);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ifa.done) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done got %b want 0", seen);
    end
    for (int i = 0; i < 4; i++) begin
      vx[i] = 8'd1;
      vw[i] = 16'sd1;
    end
    run4(7, 1'b0, lat);
    checks++;
    if (lat !== 2 || ifa.out !== 11) begin
      errors++;
      $display("FAIL midrst_rerun lat=%0d out=%0d want 2/11",
               lat, ifa.out);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    do_start(1);
    do_beat(8'd2, 16'sd3, 1'b0);
    do_beat(8'd2, 16'sd3, 1'b0);
    start = 1'b1;
    bias = 1000;
    @(posedge clk); #1;
    start = 1'b0;
    do_beat(8'd2, 16'sd3, 1'b0);
    do_beat(8'd2, 16'sd3, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 2 || ifa.out !== 25) begin
      errors++;
      $display("FAIL busy_start lat=%0d out=%0d want 2/25",
               lat, ifa.out);
    end
    do_start(-3);
    checks++;
    if (ifa.x_ready !== 1'b1) begin
      errors++;
      $display("FAIL done_start ready=%b want 1", ifa.x_ready);
    end
    for (int i = 0; i < 4; i++)
      do_beat(8'd1, 16'sd1, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 2 || ifa.out !== 1) begin
      errors++;
      $display("FAIL done_start_out lat=%0d out=%0d want 2/1",
               lat, ifa.out);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_saturation();
    test_gaps();
    test_relu();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
